// File: rtl/sc_pkg.sv
// Shared constants, grade encodings and scoring helpers for the score keeper.
package sc_pkg;

    localparam int NOTES   = 37;
    localparam int TW      = 18;
    localparam int LANE_W  = 6;
    localparam int SCORE_W = 24;
    localparam int COMBO_W = 10;

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'd0,
        GRADE_OK      = 2'd1,
        GRADE_GOOD    = 2'd2,
        GRADE_PERFECT = 2'd3
    } grade_e;

    localparam int THR_PERFECT = 20;
    localparam int THR_GOOD    = 50;
    localparam int THR_OK      = 100;

    localparam logic [1:0] PTS_PERFECT = 2'd3;
    localparam logic [1:0] PTS_GOOD    = 2'd2;
    localparam logic [1:0] PTS_OK      = 2'd1;
    localparam logic [1:0] PTS_MISS    = 2'd0;

    localparam int COMBO_STEP = 10;

    function automatic logic [1:0] base_points(input grade_e g);
        case (g)
            GRADE_PERFECT: return PTS_PERFECT;
            GRADE_GOOD:    return PTS_GOOD;
            GRADE_OK:      return PTS_OK;
            default:       return PTS_MISS;
        endcase
    endfunction

    // Multiplier grows by one every COMBO_STEP hits and caps at 4.
    function automatic logic [2:0] combo_mult(input logic [COMBO_W-1:0] c);
        if (c >= COMBO_W'(3 * COMBO_STEP)) begin
            return 3'd4;
        end else if (c >= COMBO_W'(2 * COMBO_STEP)) begin
            return 3'd3;
        end else if (c >= COMBO_W'(COMBO_STEP)) begin
            return 3'd2;
        end else begin
            return 3'd1;
        end
    endfunction

endpackage

// File: rtl/sc_priority_pick.sv
// Combinational lowest-set-bit encoder: returns index of the lowest request.
module sc_priority_pick
    import sc_pkg::*;
#(
    parameter int N  = 37,
    parameter int IW = 6
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] pick_idx,
    output logic          pick_valid
);

    // Scan upward; the first set bit found is latched by pick_valid.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            pick_idx   = (req[i] && !pick_valid) ? IW'(i) : pick_idx;
            pick_valid = pick_valid | req[i];
        end
    end

endmodule

// File: rtl/sc_score_keeper.sv
// Captures per-lane match pulses, grades one pending lane per cycle and
// accumulates score/combo statistics in a single registered stage.
module sc_score_keeper
    import sc_pkg::*;
#(
    parameter int NOTES = sc_pkg::NOTES,
    parameter int TW    = sc_pkg::TW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [NOTES-1:0]      match_trigger,
    input  logic [NOTES*TW-1:0]   match_time,
    output logic [23:0]           score,
    output logic [9:0]            combo,
    output logic [9:0]            max_combo,
    output logic                  grade_valid,
    output logic [1:0]            grade,
    output logic [5:0]            grade_lane,
    output logic                  overrun
);

    logic [NOTES-1:0]   pending_r;
    logic [TW-1:0]      hold_r [NOTES];
    logic [LANE_W-1:0]  svc_idx_s;
    logic               svc_valid_s;
    logic [NOTES-1:0]   svc_onehot_s;
    logic [TW-1:0]      hold_sel_s;
    logic               overrun_hit_s;

    grade_e             grade_s;
    logic [4:0]         points_s;
    logic [SCORE_W:0]   score_sum_s;
    logic [SCORE_W-1:0] score_next_s;
    logic [COMBO_W-1:0] combo_next_s;

    logic [SCORE_W-1:0] score_r;
    logic [COMBO_W-1:0] combo_r;
    logic [COMBO_W-1:0] max_combo_r;
    logic               grade_valid_r;
    grade_e             grade_r;
    logic [LANE_W-1:0]  grade_lane_r;
    logic               overrun_r;

    sc_priority_pick #(
        .N  (NOTES),
        .IW (LANE_W)
    ) u_pick (
        .req        (pending_r),
        .pick_idx   (svc_idx_s),
        .pick_valid (svc_valid_s)
    );

    // Select the lane being serviced this cycle and its held error.
    always_comb begin
        svc_onehot_s = '0;
        hold_sel_s   = '0;
        if (svc_valid_s) begin
            svc_onehot_s = NOTES'(1) << svc_idx_s;
            hold_sel_s   = hold_r[svc_idx_s];
        end else begin
            svc_onehot_s = '0;
            hold_sel_s   = '0;
        end
    end

    // A retrigger that the servicer is not consuming this edge loses a hit.
    assign overrun_hit_s = |(match_trigger & pending_r & ~svc_onehot_s);

    // Grade, multiplier and saturating accumulate for the serviced lane.
    always_comb begin
        grade_s = GRADE_MISS;
        if (hold_sel_s <= TW'(THR_PERFECT)) begin
            grade_s = GRADE_PERFECT;
        end else if (hold_sel_s <= TW'(THR_GOOD)) begin
            grade_s = GRADE_GOOD;
        end else if (hold_sel_s <= TW'(THR_OK)) begin
            grade_s = GRADE_OK;
        end else begin
            grade_s = GRADE_MISS;
        end

        points_s     = 5'(base_points(grade_s)) * 5'(combo_mult(combo_r));
        score_sum_s  = {1'b0, score_r} + (SCORE_W + 1)'(points_s);
        score_next_s = score_sum_s[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];

        if (grade_s == GRADE_MISS) begin
            combo_next_s = '0;
        end else if (combo_r == {COMBO_W{1'b1}}) begin
            combo_next_s = combo_r;
        end else begin
            combo_next_s = combo_r + COMBO_W'(1);
        end
    end

    // Capture triggers into hold/pending; a same-edge trigger beats the service clear.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pending_r <= '0;
            for (int i = 0; i < NOTES; i++) begin
                hold_r[i] <= '0;
            end
            overrun_r <= 1'b0;
        end else begin
            for (int i = 0; i < NOTES; i++) begin
                if (match_trigger[i]) begin
                    pending_r[i] <= 1'b1;
                    hold_r[i]    <= match_time[TW*i +: TW];
                end else if (svc_onehot_s[i]) begin
                    pending_r[i] <= 1'b0;
                end
            end
            if (overrun_hit_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Registered grade/statistics stage; last grade and lane hold when idle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            score_r       <= '0;
            combo_r       <= '0;
            max_combo_r   <= '0;
            grade_valid_r <= 1'b0;
            grade_r       <= GRADE_MISS;
            grade_lane_r  <= '0;
        end else if (svc_valid_s) begin
            grade_valid_r <= 1'b1;
            grade_r       <= grade_s;
            grade_lane_r  <= svc_idx_s;
            score_r       <= score_next_s;
            combo_r       <= combo_next_s;
            if (combo_next_s > max_combo_r) begin
                max_combo_r <= combo_next_s;
            end
        end else begin
            grade_valid_r <= 1'b0;
        end
    end

    assign score       = score_r;
    assign combo       = combo_r;
    assign max_combo   = max_combo_r;
    assign grade_valid = grade_valid_r;
    assign grade       = grade_r;
    assign grade_lane  = grade_lane_r;
    assign overrun     = overrun_r;

endmodule

// File: doc/sc_score_keeper.md
SC_SCORE_KEEPER -- requirements
Module: sc_score_keeper

Interface
REQ-001 Parameter NOTES, default 37: number of note lanes.
REQ-002 Parameter TW, default 18: width of each per-lane timing error.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  synchronous song-restart; clears statistics exactly as reset does.
REQ-006 match_trigger  input  NOTES  per-lane one-cycle match pulse from the note matcher.
REQ-007 match_time  input  NOTES*TW  per-lane unsigned absolute timing error in ms; lane i is bits [TW*i+TW-1:TW*i]; valid when its trigger is high.
REQ-008 score  output  24  accumulated score, saturating.
REQ-009 combo  output  10  current consecutive non-miss count, saturating at 1023.
REQ-010 max_combo  output  10  highest combo reached since reset/clear.
REQ-011 grade_valid  output  1  one-cycle pulse per graded hit.
REQ-012 grade  output  2  grade of the latest hit: 3 perfect, 2 good, 1 ok, 0 miss.
REQ-013 grade_lane  output  6  lane index of the latest grade.
REQ-014 overrun  output  1  sticky flag: a trigger arrived for a lane that was still pending.

Function
REQ-015 Capture: each posedge sets pending[i] and stores match_time lane i into hold[i] for every lane with match_trigger[i]=1.
REQ-016 Service: each cycle, the lowest-index set pending bit is graded from its hold value, and that pending bit is cleared at the same edge; at most one lane is serviced per cycle.
REQ-017 Latency: a lone trigger in cycle N gives grade_valid=1 in cycle N+2; score, combo and max_combo reflect that hit in the same cycle as grade_valid.
REQ-018 Grade thresholds on error e: e<=20 perfect; 21..50 good; 51..100 ok; e>100 miss.
REQ-019 Base points: perfect 3, good 2, ok 1, miss 0.
REQ-020 Multiplier m = 1 + min(combo_before/10, 3), where combo_before is the combo value before this hit; points added = base*m.
REQ-021 Non-miss: combo increments, saturating at 1023. Miss: combo becomes 0.
REQ-022 max_combo updates to the new combo whenever the new combo exceeds it.
REQ-023 Score addition saturates at 24'hFFFFFF with no wrap.
REQ-024 Same-edge trigger and service on lane i: the trigger wins; pending[i] stays set with the new hold value and overrun is not raised.
REQ-025 Trigger on a lane that is pending and not being serviced in that cycle: hold is overwritten, the older hit is dropped, and overrun is set.
REQ-026 With no pending bits, grade_valid=0 and grade/grade_lane hold their last values.

Reset
REQ-027 reset or clear: pending=0, hold=0, score=0, combo=0, max_combo=0, grade_valid=0, grade=0, grade_lane=0, overrun=0.
REQ-028 reset or clear asserted mid-operation discards all pending hits; triggers in the reset cycle are not captured.
REQ-029 clear has the same priority as reset; both take priority over all capture and service activity.

Structure
REQ-030 Shared package sc_pkg holds: grade encodings, threshold constants (20/50/100), base points, NOTES, TW, and the combo step of 10.
REQ-031 One sub-module, sc_priority_pick: combinational lowest-set-bit encoder (NOTES in; index plus any-valid out).
REQ-032 The grade, multiplier and accumulate logic form one registered stage; no other pipeline stages.

Verification
REQ-033 Lone hit, lane 5, e=15, from reset -> cycle N+2: grade_valid=1, grade=3, grade_lane=5, score=3, combo=1.
REQ-034 Triggers on lanes 2, 0 and 36 in the same cycle, e=30/60/200 -> grades in order lane0=1, lane2=2, lane36=0 on consecutive cycles; score=3, combo=0, max_combo=2.
REQ-035 25 perfect hits on lane 1, spaced 3 cycles apart -> score=3*10+6*10+9*5=135, combo=25, max_combo=25.
REQ-036 Lane 7 triggered twice in consecutive cycles while lanes 0..6 are pending -> overrun=1; a single lane-7 grade using the second error value.
REQ-037 Preload score near saturation (16777214 + perfect hit at m=4) -> score=16777215 and holds there; a clear pulse while hits are pending -> all outputs 0, no grade_valid afterward.
